// File: rtl/logic_gate_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_pipe_if
// Description : Operand/result handshake and sweep-control bundle for the
//               registered bitwise gate block. The master drives operands,
//               opcode, downstream ready and the sweep request. The slave
//               returns the result, its flags and the sweep status.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;
  logic             sweep_start;
  logic             sweep_busy;
  logic             sweep_done;
  logic [31:0]      tt_word;
  logic             lane_err;

  modport master (
    output in_valid, a, b, op, out_ready, sweep_start,
    input  in_ready, out_valid, y, zero, parity,
           sweep_busy, sweep_done, tt_word, lane_err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready, sweep_start,
    output in_ready, out_valid, y, zero, parity,
           sweep_busy, sweep_done, tt_word, lane_err
  );
endinterface
`default_nettype wire

// File: rtl/logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_pipe
// Description : One of eight bitwise gate functions applied to two WIDTH-bit
//               operands behind a valid/ready handshake with a one-stage
//               output register. A sweep engine runs all 32 (opcode, input)
//               vectors through the same gate function with lane-replicated
//               operands, and reports a truth-table word plus a flag that is
//               set when any lane disagrees with lane 0.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  logic_gate_pipe_if.slave   bus
);

  // Opcode map: 0 AND, 1 OR, 2 NOT a, 3 NOT b, 4 NAND, 5 NOR, 6 XOR, 7 XNOR.
  function automatic logic [WIDTH-1:0] gate_f(
    input logic [2:0]       op_v,
    input logic [WIDTH-1:0] a_v,
    input logic [WIDTH-1:0] b_v
  );
    logic [WIDTH-1:0] r;
    case (op_v)
      3'd0:    r = a_v & b_v;
      3'd1:    r = a_v | b_v;
      3'd2:    r = ~a_v;
      3'd3:    r = ~b_v;
      3'd4:    r = ~(a_v & b_v);
      3'd5:    r = ~(a_v | b_v);
      3'd6:    r = a_v ^ b_v;
      default: r = ~(a_v ^ b_v);
    endcase
    return r;
  endfunction

  // The ARM state holds the one-cycle gap between the sampled request and
  // the first busy cycle, so a transfer can still slip in right after the
  // request is taken.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [4:0]       k_q;
  logic [31:0]      tt_q;
  logic             lane_err_q;
  logic             busy_q;
  logic             done_q;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_gate_y;
  logic [WIDTH-1:0] w_sweep_y;
  logic             w_lane_uniform;

  assign w_in_ready = !busy_q && (!out_valid_q || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_gate_y   = gate_f(bus.op, bus.a, bus.b);

  // Sweep vector k: opcode in k[4:2], a from k[1], b from k[0], every lane.
  assign w_sweep_y      = gate_f(k_q[4:2], {WIDTH{k_q[1]}}, {WIDTH{k_q[0]}});
  assign w_lane_uniform = (w_sweep_y == '0) || (w_sweep_y == '1);

  // Output register next state: load on transfer, drop valid on drain, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      y_d         = w_gate_y;
      zero_d      = (w_gate_y == '0);
      parity_d    = ^w_gate_y;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Result register; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
    end
  end

  // Sweep engine with registered busy/done; reset aborts a sweep without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= 5'd0;
      tt_q       <= 32'd0;
      lane_err_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.sweep_start) begin
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          state_q    <= S_SWEEP;
          k_q        <= 5'd0;
          tt_q       <= 32'd0;
          lane_err_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        S_SWEEP: begin
          tt_q[k_q] <= w_sweep_y[0];
          if (!w_lane_uniform) begin
            lane_err_q <= 1'b1;
          end
          k_q <= k_q + 5'd1;
          if (k_q == 5'd31) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.y          = y_q;
  assign bus.zero       = zero_q;
  assign bus.parity     = parity_q;
  assign bus.sweep_busy = busy_q;
  assign bus.sweep_done = done_q;
  assign bus.tt_word    = tt_q;
  assign bus.lane_err   = lane_err_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_gate_pipe
// Description : Self-checking bench for logic_gate_pipe (WIDTH=8). A
//               transaction-level model derives every gate result bit by bit
//               from the published truth-table word and tracks the handshake
//               and sweep timeline as a cycle count since the request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(8)) bus ();

  logic_gate_pipe #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] tt_ref = 32'h961753E8;

  // Model state
  logic       m_valid = 1'b0;
  logic [7:0] m_y     = 8'h00;
  logic       m_zero  = 1'b0;
  logic       m_par   = 1'b0;
  int         m_age   = -1;   // edges since accepted sweep request, -1 when idle
  logic [31:0] m_tt   = 32'h0;

  function automatic logic [7:0] ref_gate(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) begin
      r[j] = tt_ref[4 * int'(o) + 2 * int'(av[j]) + int'(bv[j])];
    end
    return r;
  endfunction

  function automatic logic ref_parity(input logic [7:0] v);
    int ones = 0;
    for (int j = 0; j < 8; j++) ones += int'(v[j]);
    return logic'(ones % 2);
  endfunction

  function automatic logic m_busy();
    return (m_age >= 1) && (m_age <= 32);
  endfunction

  function automatic logic m_ready();
    return !m_busy() && (!m_valid || bus.out_ready);
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic       acc;
    logic [7:0] ny;
    acc = bus.in_valid && m_ready();
    ny  = ref_gate(bus.op, bus.a, bus.b);
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_y = 8'h00; m_zero = 1'b0; m_par = 1'b0;
      m_age = -1; m_tt = 32'h0;
    end else begin
      if (acc) begin
        m_valid = 1'b1; m_y = ny; m_zero = (ny == 8'h00); m_par = ref_parity(ny);
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
      if (m_age == 33) m_age = -1;
      else if (m_age >= 0) m_age++;
      else if (bus.sweep_start) m_age = 0;
      if (m_age == 1)  m_tt = 32'h0;
      if (m_age == 33) m_tt = tt_ref;
    end
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.op = 0; bus.out_ready = 0; bus.sweep_start = 0;
    rst = 1; tick(); tick(); rst = 0; #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.y !== 8'h00) begin n_fail++; $display("FAIL reset_y got %h want 00", bus.y); end
    n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b want 0", bus.zero); end
    n_checks++; if (bus.parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity got %b want 0", bus.parity); end
    n_checks++; if (bus.sweep_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.sweep_busy); end
    n_checks++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.sweep_done); end
    n_checks++; if (bus.tt_word !== 32'h0) begin n_fail++; $display("FAIL reset_tt got %h want 0", bus.tt_word); end
    n_checks++; if (bus.lane_err !== 1'b0) begin n_fail++; $display("FAIL reset_lane_err got %b want 0", bus.lane_err); end
  endtask

  task automatic test_truth_table();
    logic [7:0] exp_y [8] = '{8'h88, 8'hEE, 8'h33, 8'h55, 8'h77, 8'h11, 8'h66, 8'h99};
    bus.out_ready = 1; bus.in_valid = 1; bus.a = 8'hCC; bus.b = 8'hAA;
    for (int o = 0; o < 8; o++) begin
      bus.op = 3'(o);
      tick();
      n_checks++; if (bus.y !== exp_y[o] || bus.y !== m_y) begin n_fail++; $display("FAIL truth_y op%0d got %h want %h", o, bus.y, exp_y[o]); end
      n_checks++; if (bus.parity !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL truth_flags op%0d got par=%b vld=%b want 0/1", o, bus.parity, bus.out_valid); end
    end
    bus.a = 8'h00; bus.b = 8'h00; bus.op = 3'd0;
    tick();
    n_checks++; if (bus.y !== 8'h00 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL truth_zero got y=%h zero=%b want 00/1", bus.y, bus.zero); end
    bus.in_valid = 0; tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL truth_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 0; bus.in_valid = 1; bus.a = 8'hF0; bus.b = 8'h0F; bus.op = 3'd6;
    tick();
    n_checks++; if (bus.y !== 8'hFF || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_load got y=%h vld=%b want FF/1", bus.y, bus.out_valid); end
    bus.a = 8'h3C; bus.b = 8'h0F; bus.op = 3'd0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d got %b want 0", c, bus.in_ready); end
      tick();
      n_checks++; if (bus.y !== 8'hFF || bus.parity !== 1'b0 || bus.zero !== 1'b0) begin n_fail++; $display("FAIL bp_hold cyc%0d got y=%h want FF", c, bus.y); end
    end
    bus.out_ready = 1; #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
    tick();
    n_checks++; if (bus.y !== 8'h0C || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_b2b_first got y=%h vld=%b want 0C/1", bus.y, bus.out_valid); end
    bus.op = 3'd1;
    tick();
    n_checks++; if (bus.y !== 8'h3F || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_b2b_second got y=%h vld=%b want 3F/1", bus.y, bus.out_valid); end
    bus.in_valid = 0; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 80; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 3'($urandom);
      #1;
      n_checks++; if (bus.in_ready !== m_ready()) begin n_fail++; $display("FAIL rand_in_ready cyc%0d got %b want %b", c, bus.in_ready, m_ready()); end
      tick();
      n_checks++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rand_out_valid cyc%0d got %b want %b", c, bus.out_valid, m_valid); end
      n_checks++; if (bus.y !== m_y || bus.zero !== m_zero || bus.parity !== m_par) begin n_fail++; $display("FAIL rand_result cyc%0d got %h/%b/%b want %h/%b/%b", c, bus.y, bus.zero, bus.parity, m_y, m_zero, m_par); end
    end
    bus.in_valid = 0; bus.out_ready = 1; tick();
  endtask

  // Runs edges 1..34 after a request taken at edge 0; extra_start_cyc raises
  // sweep_start again at that cycle to check it is ignored.
  task automatic run_sweep(input string tag, input int extra_start_cyc, input logic check_hold);
    int busy_cnt = 0; int done_cnt = 0; int done_cyc = -1;
    for (int c = 1; c <= 34; c++) begin
      bus.sweep_start = (c == extra_start_cyc);
      if (check_hold) begin
        bus.in_valid = 1; bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 3'($urandom);
        bus.out_ready = (c >= 6);
      end
      #1;
      n_checks++; if (bus.in_ready !== m_ready()) begin n_fail++; $display("FAIL %s_in_ready cyc%0d got %b want %b", tag, c, bus.in_ready, m_ready()); end
      tick();
      if (bus.sweep_busy) busy_cnt++;
      if (bus.sweep_done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      n_checks++; if (bus.sweep_busy !== m_busy()) begin n_fail++; $display("FAIL %s_busy cyc%0d got %b want %b", tag, c, bus.sweep_busy, m_busy()); end
      n_checks++; if (bus.out_valid !== m_valid || bus.y !== m_y) begin n_fail++; $display("FAIL %s_output cyc%0d got %b/%h want %b/%h", tag, c, bus.out_valid, bus.y, m_valid, m_y); end
      if (check_hold && c <= 33) begin
        n_checks++; if (bus.y !== 8'hA5) begin n_fail++; $display("FAIL %s_pending_y cyc%0d got %h want A5", tag, c, bus.y); end
      end
    end
    bus.sweep_start = 0; bus.in_valid = 0; bus.out_ready = 1;
    n_checks++; if (busy_cnt !== 32) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want 32", tag, busy_cnt); end
    n_checks++; if (done_cyc !== 33 || done_cnt !== 1) begin n_fail++; $display("FAIL %s_done got cyc %0d count %0d want 33/1", tag, done_cyc, done_cnt); end
    n_checks++; if (bus.tt_word !== 32'h961753E8 || bus.tt_word !== m_tt) begin n_fail++; $display("FAIL %s_tt_word got %h want 961753E8", tag, bus.tt_word); end
    n_checks++; if (bus.lane_err !== 1'b0) begin n_fail++; $display("FAIL %s_lane_err got %b want 0", tag, bus.lane_err); end
    tick();
  endtask

  task automatic test_sweep();
    bus.out_ready = 0; bus.in_valid = 1; bus.a = 8'h5A; bus.b = 8'hFF; bus.op = 3'd6;
    tick();
    n_checks++; if (bus.y !== 8'hA5 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_preload got %h/%b want A5/1", bus.y, bus.out_valid); end
    bus.in_valid = 0; bus.sweep_start = 1;
    tick();
    bus.sweep_start = 0;
    run_sweep("sweep", 0, 1'b1);
  endtask

  task automatic test_sweep_restart();
    bus.in_valid = 0; bus.out_ready = 1; bus.sweep_start = 1;
    tick();
    run_sweep("restart", 10, 1'b0);
  endtask

  task automatic test_sweep_coincident();
    bus.out_ready = 1; bus.in_valid = 1; bus.a = 8'hC3; bus.b = 8'h0F; bus.op = 3'd5; bus.sweep_start = 1;
    tick();
    n_checks++; if (bus.y !== 8'h30 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL coinc_result got %h/%b want 30/1", bus.y, bus.out_valid); end
    bus.in_valid = 0; bus.sweep_start = 0;
    run_sweep("coinc", 0, 1'b0);
  endtask

  task automatic test_sweep_reset();
    int done_seen = 0;
    bus.in_valid = 0; bus.out_ready = 1; bus.sweep_start = 1;
    tick();
    bus.sweep_start = 0;
    repeat (10) tick();
    rst = 1; tick(); rst = 0;
    n_checks++; if (bus.sweep_busy !== 1'b0 || bus.tt_word !== 32'h0 || bus.lane_err !== 1'b0) begin n_fail++; $display("FAIL abort_state got busy=%b tt=%h err=%b want 0/0/0", bus.sweep_busy, bus.tt_word, bus.lane_err); end
    repeat (36) begin tick(); if (bus.sweep_done) done_seen++; end
    n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", done_seen); end
    bus.sweep_start = 1;
    tick();
    bus.sweep_start = 0;
    run_sweep("after_abort", 0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_truth_table();
    test_backpressure();
    test_random();
    test_sweep();
    test_sweep_restart();
    test_sweep_coincident();
    test_sweep_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
